// File: rtl/hls_perf_monitor_if.sv
// Monitor-side bundle: ap_ctrl_chain taps, iteration pulses, busy flags and
// the completed-record read port.
interface hls_perf_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0] ap_start;
  logic [NUM_CH-1:0] ap_done;
  logic [NUM_CH-1:0] ap_continue;
  logic [NUM_CH-1:0] iter_start;
  logic [NUM_CH-1:0] busy;
  logic              rec_valid;
  logic              rec_ready;
  logic [CH_W-1:0]   rec_ch;
  logic [CNT_W-1:0]  rec_latency;
  logic [CNT_W-1:0]  rec_iters;
  logic [CNT_W-1:0]  rec_stall;
  logic [CNT_W-1:0]  drop_count;

  modport master (
    output ap_start, ap_done, ap_continue, iter_start, rec_ready,
    input  busy, rec_valid, rec_ch, rec_latency, rec_iters, rec_stall, drop_count
  );

  modport slave (
    input  ap_start, ap_done, ap_continue, iter_start, rec_ready,
    output busy, rec_valid, rec_ch, rec_latency, rec_iters, rec_stall, drop_count
  );
endinterface

// File: rtl/hls_perf_monitor.sv
// Multi-channel ap_ctrl_chain performance monitor: per-channel latency,
// iteration and output-stall counters, single-entry pending slots, a
// round-robin arbiter and a show-ahead record FIFO.
module hls_perf_monitor #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  hls_perf_monitor_if.slave mon
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != CNT_MAX)) ? v + CNT_ONE : v;
  endfunction

  state_t           state     [NUM_CH];
  state_t           state_nxt [NUM_CH];
  logic [CNT_W-1:0] lat [NUM_CH], lat_nxt [NUM_CH];
  logic [CNT_W-1:0] its [NUM_CH], its_nxt [NUM_CH];
  logic [CNT_W-1:0] stl [NUM_CH], stl_nxt [NUM_CH];
  logic [CNT_W-1:0] cmp_lat [NUM_CH], cmp_its [NUM_CH], cmp_stl [NUM_CH];
  logic [NUM_CH-1:0] cmp;

  logic [NUM_CH-1:0] vld_p0;
  logic [CNT_W-1:0]  lat_p0 [NUM_CH], its_p0 [NUM_CH], stl_p0 [NUM_CH];
  logic [CNT_W-1:0]  drop_cnt, drop_nxt;

  logic [NUM_CH-1:0] grant;
  logic              gany;
  logic [CH_W-1:0]   gsel, rr_ptr;

  logic [AW:0]       fifo_cnt;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CH_W-1:0]   mem_ch  [FIFO_DEPTH];
  logic [CNT_W-1:0]  mem_lat [FIFO_DEPTH], mem_its [FIFO_DEPTH], mem_stl [FIFO_DEPTH];
  logic              fifo_vld, push, pop;

  // Channel FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) state[c] <= IDLE;
    end else begin
      for (int c = 0; c < NUM_CH; c++) state[c] <= state_nxt[c];
    end
  end

  // Channel FSM next state and completion detection; a completion that
  // coincides with a new armed start re-enters RUN directly.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      state_nxt[c] = state[c];
      cmp[c]       = 1'b0;
      case (state[c])
        IDLE: if (enable && mon.ap_start[c]) begin
          if (mon.ap_done[c] && mon.ap_continue[c]) cmp[c] = 1'b1;
          else if (mon.ap_done[c])                  state_nxt[c] = HOLD;
          else                                      state_nxt[c] = RUN;
        end
        RUN: if (mon.ap_done[c]) begin
          if (mon.ap_continue[c]) begin
            cmp[c]       = 1'b1;
            state_nxt[c] = (enable && mon.ap_start[c]) ? RUN : IDLE;
          end else begin
            state_nxt[c] = HOLD;
          end
        end
        HOLD: if (mon.ap_continue[c]) begin
          cmp[c]       = 1'b1;
          state_nxt[c] = (enable && mon.ap_start[c]) ? RUN : IDLE;
        end
        default: state_nxt[c] = IDLE;
      endcase
    end
  end

  // Channel FSM outputs: counter updates, completed-record values, busy
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      lat_nxt[c]  = lat[c];
      its_nxt[c]  = its[c];
      stl_nxt[c]  = stl[c];
      cmp_lat[c]  = sat_inc(lat[c], 1'b1);
      cmp_its[c]  = sat_inc(its[c], mon.iter_start[c]);
      cmp_stl[c]  = stl[c];
      mon.busy[c] = (state[c] != IDLE);
      case (state[c])
        IDLE: begin
          cmp_lat[c] = CNT_ONE;
          cmp_its[c] = CNT_W'(mon.iter_start[c]);
          cmp_stl[c] = '0;
          if (enable && mon.ap_start[c]) begin
            lat_nxt[c] = CNT_ONE;
            its_nxt[c] = CNT_W'(mon.iter_start[c]);
            stl_nxt[c] = (mon.ap_done[c] && !mon.ap_continue[c]) ? CNT_ONE : '0;
          end
        end
        RUN: begin
          lat_nxt[c] = sat_inc(lat[c], 1'b1);
          its_nxt[c] = sat_inc(its[c], mon.iter_start[c]);
          if (mon.ap_done[c] && !mon.ap_continue[c]) stl_nxt[c] = sat_inc(stl[c], 1'b1);
        end
        HOLD: begin
          cmp_its[c] = its[c];
          lat_nxt[c] = sat_inc(lat[c], 1'b1);
          if (!mon.ap_continue[c]) stl_nxt[c] = sat_inc(stl[c], 1'b1);
        end
        default: ;
      endcase
      if (cmp[c] && (state[c] != IDLE) && enable && mon.ap_start[c]) begin
        lat_nxt[c] = CNT_ONE;
        its_nxt[c] = CNT_W'(mon.iter_start[c]);
        stl_nxt[c] = '0;
      end
    end
  end

  // Channel counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        lat[c] <= '0;
        its[c] <= '0;
        stl[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        lat[c] <= lat_nxt[c];
        its[c] <= its_nxt[c];
        stl[c] <= stl_nxt[c];
      end
    end
  end

  // Drops: completion into an occupied slot that is not draining this cycle
  always_comb begin
    drop_nxt = drop_cnt;
    for (int c = 0; c < NUM_CH; c++)
      drop_nxt = sat_inc(drop_nxt, cmp[c] && vld_p0[c] && !grant[c]);
  end

  // Pending slots: capture completions, release on grant, count drops
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p0   <= '0;
      drop_cnt <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        lat_p0[c] <= '0;
        its_p0[c] <= '0;
        stl_p0[c] <= '0;
      end
    end else begin
      drop_cnt <= drop_nxt;
      for (int c = 0; c < NUM_CH; c++) begin
        if (cmp[c] && (!vld_p0[c] || grant[c])) begin
          vld_p0[c] <= 1'b1;
          lat_p0[c] <= cmp_lat[c];
          its_p0[c] <= cmp_its[c];
          stl_p0[c] <= cmp_stl[c];
        end else if (grant[c]) begin
          vld_p0[c] <= 1'b0;
        end
      end
    end
  end

  // Round-robin arbiter, searching from rr_ptr; idle while the FIFO is full
  always_comb begin
    gany  = 1'b0;
    gsel  = '0;
    grant = '0;
    if (fifo_cnt < DEPTH_C) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!gany && vld_p0[(int'(rr_ptr) + k) % NUM_CH]) begin
          gany = 1'b1;
          gsel = CH_W'((int'(rr_ptr) + k) % NUM_CH);
        end
      end
    end
    if (gany) grant[gsel] = 1'b1;
  end

  assign fifo_vld = (fifo_cnt != '0);
  assign push     = gany;
  assign pop      = fifo_vld && mon.rec_ready;

  // FIFO control: pointers, occupancy, arbitration pointer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (int'(gsel) == NUM_CH - 1) ? '0 : gsel + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // FIFO storage, written with the granted slot's record
  always_ff @(posedge clock) begin
    if (push) begin
      mem_ch[wr_ptr]  <= gsel;
      mem_lat[wr_ptr] <= lat_p0[gsel];
      mem_its[wr_ptr] <= its_p0[gsel];
      mem_stl[wr_ptr] <= stl_p0[gsel];
    end
  end

  // Show-ahead read port; fields read as zero while the FIFO is empty
  always_comb begin
    mon.rec_valid   = fifo_vld;
    mon.rec_ch      = fifo_vld ? mem_ch[rd_ptr]  : '0;
    mon.rec_latency = fifo_vld ? mem_lat[rd_ptr] : '0;
    mon.rec_iters   = fifo_vld ? mem_its[rd_ptr] : '0;
    mon.rec_stall   = fifo_vld ? mem_stl[rd_ptr] : '0;
    mon.drop_count  = drop_cnt;
  end
endmodule

// File: tb/tb_hls_perf_monitor.sv
// Directed bench for hls_perf_monitor: a 4-channel 32-bit instance and a
// 1-channel 4-bit instance for counter saturation.
module tb_hls_perf_monitor;
  logic clock = 1'b0;
  logic reset;
  logic enable;
  int   n_checks = 0;
  int   n_errors = 0;

  hls_perf_monitor_if #(.NUM_CH(4), .CNT_W(32)) mon  ();
  hls_perf_monitor_if #(.NUM_CH(1), .CNT_W(4))  mons ();

  hls_perf_monitor #(.NUM_CH(4), .CNT_W(32), .FIFO_DEPTH(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .mon(mon.slave)
  );

  hls_perf_monitor #(.NUM_CH(1), .CNT_W(4), .FIFO_DEPTH(2)) dut_s (
    .clock(clock), .reset(reset), .enable(enable), .mon(mons.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] s, input logic [3:0] d, input logic [3:0] c, input logic [3:0] it);
    mon.ap_start    = s;
    mon.ap_done     = d;
    mon.ap_continue = c;
    mon.iter_start  = it;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Check the head record, then pop it
  task automatic take_rec(input int ch, input int lat, input int its, input int stl);
    @(negedge clock);
    check("rec_valid", 64'(mon.rec_valid), 64'(1));
    check("rec_ch", 64'(mon.rec_ch), 64'(ch));
    check("rec_latency", 64'(mon.rec_latency), 64'(lat));
    check("rec_iters", 64'(mon.rec_iters), 64'(its));
    check("rec_stall", 64'(mon.rec_stall), 64'(stl));
    mon.rec_ready = 1'b1;
    step();
    mon.rec_ready = 1'b0;
    @(negedge clock);
    check("rec_popped", 64'(mon.rec_valid), 64'(0));
    step();
  endtask

  initial begin
    int got;
    int budget;
    reset  = 1'b1;
    enable = 1'b1;
    drive(4'b0, 4'b0, 4'b0, 4'b0);
    mon.rec_ready    = 1'b0;
    mons.ap_start    = 1'b0;
    mons.ap_done     = 1'b0;
    mons.ap_continue = 1'b0;
    mons.iter_start  = 1'b0;
    mons.rec_ready   = 1'b0;
    step();
    step();
    check("rst_valid", 64'(mon.rec_valid), 64'(0));
    check("rst_busy", 64'(mon.busy), 64'(0));
    check("rst_drop", 64'(mon.drop_count), 64'(0));
    check("rst_latency", 64'(mon.rec_latency), 64'(0));
    check("rst_ch", 64'(mon.rec_ch), 64'(0));
    reset = 1'b0;

    // Basic run on ch0: done at cycle 9, iterations at 1..3
    for (int k = 0; k < 13; k++) begin
      drive((k == 0) ? 4'b0001 : 4'b0000, (k == 9) ? 4'b0001 : 4'b0000,
            (k == 9) ? 4'b0001 : 4'b0000, (k >= 1 && k <= 3) ? 4'b0001 : 4'b0000);
      @(negedge clock);
      check("t1_busy0", 64'(mon.busy[0]), 64'(k >= 1 && k <= 9));
      check("t1_valid", 64'(mon.rec_valid), 64'(k >= 11));
      step();
    end
    drive(4'b0, 4'b0, 4'b0, 4'b0);
    take_rec(0, 10, 3, 0);

    // ch2 with output back-pressure: continue low cycles 5..8
    for (int k = 0; k < 13; k++) begin
      drive((k == 0) ? 4'b0100 : 4'b0000, (k >= 5 && k <= 9) ? 4'b0100 : 4'b0000,
            (k == 9) ? 4'b0100 : 4'b0000, 4'b0000);
      @(negedge clock);
      check("t2_busy2", 64'(mon.busy[2]), 64'(k >= 1 && k <= 9));
      check("t2_valid", 64'(mon.rec_valid), 64'(k >= 11));
      step();
    end
    drive(4'b0, 4'b0, 4'b0, 4'b0);
    take_rec(2, 10, 0, 4);

    // Starts are ignored while disarmed
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(4'b1000, (k == 1) ? 4'b1000 : 4'b0000, (k == 1) ? 4'b1000 : 4'b0000, 4'b1000);
      @(negedge clock);
      check("t_dis_busy3", 64'(mon.busy[3]), 64'(0));
      check("t_dis_valid", 64'(mon.rec_valid), 64'(0));
      step();
    end
    enable = 1'b1;
    drive(4'b0, 4'b0, 4'b0, 4'b0);

    // All four channels complete together; round-robin order from ch0, twice
    do_reset();
    mon.rec_ready = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 10; k++) begin
        drive((k == 0) ? 4'b1111 : 4'b0000, (k == 2) ? 4'b1111 : 4'b0000,
              (k == 2) ? 4'b1111 : 4'b0000, 4'b0000);
        @(negedge clock);
        check("t3_valid", 64'(mon.rec_valid), 64'(k >= 4 && k <= 7));
        if (k >= 4 && k <= 7) begin
          check("t3_ch", 64'(mon.rec_ch), 64'(k - 4));
          check("t3_latency", 64'(mon.rec_latency), 64'(3));
        end
        step();
      end
    end
    mon.rec_ready = 1'b0;

    // Overflow: 18 back-to-back immediate completions into a stalled FIFO
    for (int k = 0; k < 18; k++) begin
      drive(4'b0001, 4'b0001, 4'b0001, (k % 2 == 1) ? 4'b0001 : 4'b0000);
      step();
    end
    drive(4'b0, 4'b0, 4'b0, 4'b0);
    step();
    step();
    @(negedge clock);
    check("t4_drop", 64'(mon.drop_count), 64'(1));
    check("t4_valid", 64'(mon.rec_valid), 64'(1));
    check("t4_busy", 64'(mon.busy), 64'(0));
    step();
    got    = 0;
    budget = 0;
    mon.rec_ready = 1'b1;
    while (got < 17 && budget < 60) begin
      @(negedge clock);
      if (mon.rec_valid) begin
        check("t4_iters", 64'(mon.rec_iters), 64'(got % 2));
        check("t4_latency", 64'(mon.rec_latency), 64'(1));
        got++;
      end
      step();
      budget++;
    end
    check("t4_count", 64'(got), 64'(17));
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("t4_empty", 64'(mon.rec_valid), 64'(0));
      step();
    end
    mon.rec_ready = 1'b0;

    // 4-bit counters saturate on a 20-cycle run
    for (int k = 0; k < 22; k++) begin
      mons.ap_start    = 1'(k == 0);
      mons.iter_start  = 1'(k <= 19);
      mons.ap_done     = 1'(k == 19);
      mons.ap_continue = 1'(k == 19);
      @(negedge clock);
      if (k == 20) check("t5_valid_early", 64'(mons.rec_valid), 64'(0));
      if (k == 21) begin
        check("t5_valid", 64'(mons.rec_valid), 64'(1));
        check("t5_latency", 64'(mons.rec_latency), 64'(15));
        check("t5_iters", 64'(mons.rec_iters), 64'(15));
        check("t5_stall", 64'(mons.rec_stall), 64'(0));
      end
      step();
    end
    mons.ap_start    = 1'b0;
    mons.iter_start  = 1'b0;
    mons.ap_done     = 1'b0;
    mons.ap_continue = 1'b0;

    // Asynchronous reset with ch1 running and two records queued
    for (int k = 0; k < 6; k++) begin
      if (k == 0)      drive(4'b0011, 4'b0001, 4'b0001, 4'b0000);
      else if (k == 1) drive(4'b0001, 4'b0001, 4'b0001, 4'b0000);
      else             drive(4'b0000, 4'b0000, 4'b0000, 4'b0000);
      step();
    end
    @(negedge clock);
    check("t6_pre_busy1", 64'(mon.busy[1]), 64'(1));
    check("t6_pre_valid", 64'(mon.rec_valid), 64'(1));
    check("t6_pre_drop", 64'(mon.drop_count), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    check("t6_valid", 64'(mon.rec_valid), 64'(0));
    check("t6_busy", 64'(mon.busy), 64'(0));
    check("t6_drop", 64'(mon.drop_count), 64'(0));
    check("t6_latency", 64'(mon.rec_latency), 64'(0));
    step();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive((k == 0) ? 4'b0010 : 4'b0000, (k == 2) ? 4'b0010 : 4'b0000,
            (k == 2) ? 4'b0010 : 4'b0000, 4'b0000);
      @(negedge clock);
      check("t6_run_valid", 64'(mon.rec_valid), 64'(k >= 4));
      if (k == 4) begin
        check("t6_run_ch", 64'(mon.rec_ch), 64'(1));
        check("t6_run_latency", 64'(mon.rec_latency), 64'(3));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
